// File: rtl/clk_phase_pkg.sv
// Shared types and constants for the quadrature phase selector.
package clk_phase_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_GAP
  } state_e;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  localparam int GAP_W = 4;

endpackage

// File: rtl/clk_phase_src.sv
// Free-running 2-bit phase counter and decode of the four quadrature phases.
module clk_phase_src (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] phase_cnt,
  output logic [3:0] raw
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  assign cnt_d     = cnt_q + 2'd1;
  assign phase_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  // Phase s is high for the two counts starting at s, so it leads phase s+1 by one cycle.
  always_comb begin
    logic [1:0] diff;
    raw  = '0;
    diff = '0;
    for (int s = 0; s < 4; s++) begin
      diff   = cnt_q - s[1:0];
      raw[s] = ~diff[1];
    end
  end

endmodule

// File: rtl/clk_phase_sel_ctrl.sv
// Glitch-free selector that drives one of four quadrature phases onto phase_out and
// switches between them via a valid/ready request (drain, forced-low gap, arm).
module clk_phase_sel_ctrl
  import clk_phase_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int RESET_SEL  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic       phase_out,
  output logic [1:0] cur_sel,
  output logic [1:0] phase_cnt,
  output logic       busy,
  output logic       switch_done
);

  localparam logic [1:0]       RST_SEL = RESET_SEL[1:0];
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_CYCLES[GAP_W-1:0];

  logic [3:0] raw;

  clk_phase_src u_src (
    .clk       (clk),
    .rst       (rst),
    .phase_cnt (phase_cnt),
    .raw       (raw)
  );

  state_e           state_q, state_d;
  logic [1:0]       cur_sel_q, cur_sel_d;
  logic [1:0]       tgt_sel_q, tgt_sel_d;
  logic             pend_q, pend_d;
  logic             off_pend_q, off_pend_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             phase_out_q, phase_out_d;
  logic             switch_done_q, switch_done_d;

  logic raw_cur;
  logic gate;
  logic accept;

  // Handshake: a request transfers on a cycle where req_valid and req_ready are both high;
  // req_sel is captured only on that cycle. req_ready depends on registers and en only.
  assign req_ready = ((state_q == ST_RUN && en) || state_q == ST_OFF)
                     && !pend_q && !switch_done_q && !rst;
  assign accept    = req_valid && req_ready;

  assign raw_cur = raw[cur_sel_q];
  // While draining, the in-flight high pulse is allowed to finish at full width.
  assign gate    = (state_q == ST_RUN) || (state_q == ST_DRAIN && raw_cur);

  always_comb begin
    state_d       = state_q;
    cur_sel_d     = cur_sel_q;
    tgt_sel_d     = tgt_sel_q;
    pend_d        = pend_q;
    off_pend_d    = off_pend_q;
    gap_d         = gap_q;
    switch_done_d = 1'b0;
    phase_out_d   = gate && raw_cur;

    unique case (state_q)
      ST_OFF: begin
        if (accept) begin
          cur_sel_d     = req_sel;
          tgt_sel_d     = req_sel;
          switch_done_d = 1'b1;
        end else if (en) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!en) begin
          state_d = ST_OFF;
        end else if (!raw_cur) begin
          state_d = ST_RUN;
          if (pend_q) begin
            switch_done_d = 1'b1;
            pend_d        = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d    = ST_DRAIN;
          off_pend_d = 1'b1;
        end else if (accept) begin
          if (req_sel == cur_sel_q) begin
            switch_done_d = 1'b1;
          end else begin
            tgt_sel_d = req_sel;
            pend_d    = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!raw_cur) begin
          gap_d   = GAP_LD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d      = '0;
          if (pend_q) cur_sel_d = tgt_sel_q;
          state_d    = off_pend_q ? ST_OFF : ST_ARM;
          off_pend_d = 1'b0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      cur_sel_q     <= RST_SEL;
      tgt_sel_q     <= RST_SEL;
      pend_q        <= 1'b0;
      off_pend_q    <= 1'b0;
      gap_q         <= '0;
      phase_out_q   <= 1'b0;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_sel_q     <= cur_sel_d;
      tgt_sel_q     <= tgt_sel_d;
      pend_q        <= pend_d;
      off_pend_q    <= off_pend_d;
      gap_q         <= gap_d;
      phase_out_q   <= phase_out_d;
      switch_done_q <= switch_done_d;
    end
  end

  assign phase_out   = phase_out_q;
  assign cur_sel     = cur_sel_q;
  assign switch_done = switch_done_q;
  assign busy        = (state_q == ST_DRAIN) || (state_q == ST_GAP) || (state_q == ST_ARM);

endmodule
